// File: rtl/decoder_scan_n.sv
// rtl/decoder_scan_n.sv - registered one-hot decoder with direct-load and auto-scan modes
module decoder_scan_n #(
  parameter int SEL_W      = 2,
  parameter int NUM_OUT    = 4,
  parameter int DWELL_W    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               load,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NUM_OUT-1:0] y,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Highest legal index; scan wraps on compare against this, not on counter overflow.
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);
  // One bit wider than sel so NUM_OUT == 2**SEL_W is representable.
  localparam logic [SEL_W:0] NUM_OUT_X = (SEL_W + 1)'(NUM_OUT);
  // Level driven on every line while disabled.
  localparam logic [NUM_OUT-1:0] Y_IDLE = (ACTIVE_LOW != 0) ? {NUM_OUT{1'b1}} : {NUM_OUT{1'b0}};

  state_t             state_q;
  state_t             state_d;
  logic [SEL_W-1:0]   idx_q;
  logic [SEL_W-1:0]   idx_d;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;
  logic               wrap_d;
  logic               err_d;
  logic [NUM_OUT-1:0] onehot;
  logic [NUM_OUT-1:0] y_d;
  logic               sel_in_range;
  logic               load_ok;
  logic               load_bad;

  assign sel_in_range = ({1'b0, sel} < NUM_OUT_X);
  assign load_ok      = load & sel_in_range;
  assign load_bad     = load & ~sel_in_range;

  // State register; reset aborts any scan and returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state from en/mode, plus next index, dwell counter and pulse outputs.
  always_comb begin
    state_d = IDLE;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;

    if (en) begin
      state_d = mode ? SCAN : DIRECT;
    end

    case (state_d)
      DIRECT: begin
        err_d = load_bad;
        if (load_ok) begin
          idx_d = sel;
        end
      end
      SCAN: begin
        err_d = load_bad;
        if (load_ok) begin
          // A legal load overrides both scan entry and a same-cycle advance.
          idx_d = sel;
          cnt_d = dwell;
        end else if (state_q != SCAN) begin
          idx_d = '0;
          cnt_d = dwell;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          cnt_d = dwell;
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Decode the next index into the line pattern that will be registered onto y.
  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      onehot[k] = (idx_d == SEL_W'(k));
    end
    if (state_d == IDLE) begin
      y_d = Y_IDLE;
    end else if (ACTIVE_LOW != 0) begin
      y_d = ~onehot;
    end else begin
      y_d = onehot;
    end
  end

  // Registered datapath and outputs; everything appears one cycle after sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
      y     <= Y_IDLE;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      y     <= y_d;
      wrap  <= wrap_d;
      err   <= err_d;
    end
  end

  assign idx = idx_q;

endmodule
